fft_frame_tx: RTL and testbench

FFT_FRAME_TX -- requirements
Module: fft_frame_tx

---
 rtl/constants_uart.sv | 47 ++++
 rtl/fft_frame_tx.sv | 181 ++++++++++++++++++
 tb/tb_fft_frame_tx.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/constants_uart.sv
// Shared framing constants for the FFT UART link (transmit and receive controllers).
// Holds the frame delimiters, frame-size codes, the transmit state encoding and
// the coefficient pair payload type.
// Optional build macro: FRAME_CHECKSUM_EN adds the CHK state to the encoding.
package constants_uart;

    localparam logic [7:0] START_BYTE   = 8'hAA;
    localparam logic [7:0] STOP_BYTE    = 8'h55;

    localparam logic [1:0] SELECT_FFT8  = 2'b00;
    localparam logic [1:0] SELECT_FFT16 = 2'b01;
    localparam logic [1:0] SELECT_FFT32 = 2'b10;

    // Fixed encodings so both link ends agree on state values.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_SELECT = 4'd2,
        ST_LOAD   = 4'd3,
        ST_R_HI   = 4'd4,
        ST_R_LO   = 4'd5,
        ST_I_HI   = 4'd6,
        ST_I_LO   = 4'd7,
`ifdef FRAME_CHECKSUM_EN
        ST_CHK    = 4'd8,
`endif
        ST_STOP   = 4'd9,
        ST_DONE   = 4'd10
    } tx_state_e;

    // One Q8.8 complex coefficient.
    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } coeff_pair_t;

    // Samples per frame for a size code; 0 marks an unsupported code.
    function automatic int unsigned frame_len(input logic [1:0] code);
        case (code)
            SELECT_FFT8:  frame_len = 8;
            SELECT_FFT16: frame_len = 16;
            SELECT_FFT32: frame_len = 32;
            default:      frame_len = 0;
        endcase
    endfunction

endpackage

// File: rtl/fft_frame_tx.sv
// fft_frame_tx: serialises one FFT coefficient frame into bytes for a UART
// byte transmitter: START, select code, N x {R_hi, R_lo, I_hi, I_lo}, [CHK], STOP.
// Ports:
//   clk, rst            clock, async active-low reset
//   start_i, fft_select_i  frame request and size code (latched at start)
//   coeff_valid_i, coeff_R_i, coeff_I_i, coeff_ready_o  coefficient pair handshake
//   byte_o, byte_valid_o, byte_ready_i                   byte stream handshake
//   busy_o, done_o, err_o                                 status
// Optional build macro: FRAME_CHECKSUM_EN inserts an XOR checksum byte before STOP.
module fft_frame_tx
    import constants_uart::*;
#(
    parameter int unsigned MAX_POINTS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  fft_select_i,
    input  logic        coeff_valid_i,
    input  logic [15:0] coeff_R_i,
    input  logic [15:0] coeff_I_i,
    output logic        coeff_ready_o,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_POINTS) + 1;

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [1:0]       sel_q, sel_d;
    coeff_pair_t      pair_q, pair_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif
    logic [7:0]       byte_q, byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             coeff_ready_q, coeff_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             byte_acc;
    logic             start_ok;

    assign byte_acc = byte_valid_q && byte_ready_i;
    assign start_ok = (frame_len(fft_select_i) != 0) && (frame_len(fft_select_i) <= MAX_POINTS);

    // Next state, datapath and next registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sel_d   = sel_q;
        pair_d  = pair_q;
        err_d   = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        chk_d   = chk_q;
        if (byte_acc && (state_q inside {ST_SELECT, ST_R_HI, ST_R_LO, ST_I_HI, ST_I_LO})) begin
            chk_d = chk_q ^ byte_q;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (start_ok) begin
                        state_d = ST_START;
                        sel_d   = fft_select_i;
                        len_d   = CNT_W'(frame_len(fft_select_i));
                        cnt_d   = '0;
`ifdef FRAME_CHECKSUM_EN
                        chk_d   = 8'h00;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_START:  if (byte_acc) state_d = ST_SELECT;
            ST_SELECT: if (byte_acc) state_d = ST_LOAD;
            ST_LOAD: begin
                if (coeff_valid_i && coeff_ready_q) begin
                    pair_d  = '{re: coeff_R_i, im: coeff_I_i};
                    state_d = ST_R_HI;
                end
            end
            ST_R_HI:   if (byte_acc) state_d = ST_R_LO;
            ST_R_LO:   if (byte_acc) state_d = ST_I_HI;
            ST_I_HI:   if (byte_acc) state_d = ST_I_LO;
            ST_I_LO: begin
                if (byte_acc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) begin
`ifdef FRAME_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CHK:    if (byte_acc) state_d = ST_STOP;
`endif
            ST_STOP:   if (byte_acc) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Outputs follow the state being entered, so they are registered yet
        // aligned with it; a stalled byte keeps identical inputs and stays stable.
        byte_d       = 8'h00;
        byte_valid_d = 1'b1;
        case (state_d)
            ST_START:  byte_d = START_BYTE;
            ST_SELECT: byte_d = {6'b0, sel_d};
            ST_R_HI:   byte_d = pair_d.re[15:8];
            ST_R_LO:   byte_d = pair_d.re[7:0];
            ST_I_HI:   byte_d = pair_d.im[15:8];
            ST_I_LO:   byte_d = pair_d.im[7:0];
`ifdef FRAME_CHECKSUM_EN
            ST_CHK:    byte_d = chk_d;
`endif
            ST_STOP:   byte_d = STOP_BYTE;
            default:   byte_valid_d = 1'b0;
        endcase
        coeff_ready_d = (state_d == ST_LOAD);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            sel_q         <= 2'b00;
            pair_q        <= '0;
`ifdef FRAME_CHECKSUM_EN
            chk_q         <= 8'h00;
`endif
            byte_q        <= 8'h00;
            byte_valid_q  <= 1'b0;
            coeff_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            sel_q         <= sel_d;
            pair_q        <= pair_d;
`ifdef FRAME_CHECKSUM_EN
            chk_q         <= chk_d;
`endif
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            coeff_ready_q <= coeff_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = byte_valid_q;
    assign coeff_ready_o = coeff_ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fft_frame_tx.sv
// Testbench for fft_frame_tx: directed frame scenarios with randomized data and
// sink backpressure, compared against a byte-list model of the frame format.
`timescale 1ns/1ps
module tb_fft_frame_tx;
    import constants_uart::*;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  fft_select_i;
    logic        coeff_valid_i;
    logic [15:0] coeff_R_i;
    logic [15:0] coeff_I_i;
    logic        coeff_ready_o;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    fft_frame_tx #(.MAX_POINTS(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .fft_select_i  (fft_select_i),
        .coeff_valid_i (coeff_valid_i),
        .coeff_R_i     (coeff_R_i),
        .coeff_I_i     (coeff_I_i),
        .coeff_ready_o (coeff_ready_o),
        .byte_o        (byte_o),
        .byte_valid_o  (byte_valid_o),
        .byte_ready_i  (byte_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    logic [15:0] src_r[$];
    logic [15:0] src_i[$];
    int          src_idx;
    int          src_n;
    bit          src_hold;
    int          rdy_mode;
    int          done_cnt;
    int          err_cnt;

`ifdef FRAME_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Sink monitor: collects accepted bytes, checks stall stability, counts pulses.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_byte;
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(byte_valid_o), 32'd1);
                    check("stall_byte", 32'(byte_o), 32'(prev_byte));
                end
                check("no_byte_in_load", 32'(byte_valid_o && coeff_ready_o), 32'd0);
                if (byte_valid_o && byte_ready_i) got.push_back(byte_o);
                prev_stall = byte_valid_o && !byte_ready_i;
                prev_byte  = byte_o;
                if (done_o) done_cnt++;
                if (err_o)  err_cnt++;
            end
        end
    end

    // Sink ready pattern: 0 always ready, 1 repeating 1-0-0, otherwise random.
    initial begin
        int phase;
        phase = 0;
        byte_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: byte_ready_i = 1'b1;
                1: begin
                    byte_ready_i = (phase == 0);
                    phase = (phase == 2) ? 0 : phase + 1;
                end
                default: byte_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Coefficient source: offers the queued pairs in order.
    initial begin
        bit acc;
        coeff_valid_i = 1'b0;
        coeff_R_i     = 16'h0000;
        coeff_I_i     = 16'h0000;
        forever begin
            @(negedge clk);
            acc = coeff_valid_i && coeff_ready_o;
            @(posedge clk);
            #1;
            if (acc) src_idx++;
            if (!src_hold && src_idx < src_n) begin
                coeff_valid_i = 1'b1;
                coeff_R_i     = src_r[src_idx];
                coeff_I_i     = src_i[src_idx];
            end else begin
                coeff_valid_i = 1'b0;
            end
        end
    end

    // Reference frame: kind 0 = ramp pattern, 1 = random, 2 = all zero.
    task automatic build(input logic [1:0] code, input int kind);
        int n;
        n = 8 << code;
        src_r.delete();
        src_i.delete();
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            case (kind)
                0: begin src_r.push_back(16'(16'h0100 + k)); src_i.push_back(16'(16'hFF00 - k)); end
                1: begin src_r.push_back(16'($urandom)); src_i.push_back(16'($urandom)); end
                default: begin src_r.push_back(16'h0000); src_i.push_back(16'h0000); end
            endcase
        end
        exp_q.push_back(START_BYTE);
        exp_q.push_back({6'b0, code});
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(src_r[k][15:8]);
            exp_q.push_back(src_r[k][7:0]);
            exp_q.push_back(src_i[k][15:8]);
            exp_q.push_back(src_i[k][7:0]);
        end
`ifdef FRAME_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int j = 1; j < exp_q.size(); j++) x = x ^ exp_q[j];
            exp_q.push_back(x);
        end
`endif
        exp_q.push_back(STOP_BYTE);
        src_idx = 0;
        src_n   = n;
    endtask

    task automatic pulse_start(input logic [1:0] code, input logic [1:0] after);
        @(posedge clk); #2;
        start_i      = 1'b1;
        fft_select_i = code;
        @(posedge clk); #2;
        start_i      = 1'b0;
        fft_select_i = after;
    endtask

    task automatic run_frame(input logic [1:0] code, input int mode, input int kind,
                             input bit starve, input bit poke);
        build(code, kind);
        got.delete();
        done_cnt = 0;
        err_cnt  = 0;
        rdy_mode = mode;
        src_hold = starve;
        pulse_start(code, ~code);
        @(negedge clk);
        check("busy_after_start", 32'(busy_o), 32'd1);
        if (starve) begin
            for (int c = 0; c < 200 && !coeff_ready_o; c++) @(negedge clk);
            check("reach_load", 32'(coeff_ready_o), 32'd1);
            for (int c = 0; c < 20; c++) begin
                check("starve_no_byte", 32'(byte_valid_o), 32'd0);
                check("starve_hold_load", 32'(coeff_ready_o), 32'd1);
                @(negedge clk);
            end
            check("starve_bytes", 32'(got.size()), 32'd2);
            src_hold = 1'b0;
        end
        if (poke) begin
            for (int c = 0; c < 500 && got.size() < 5; c++) @(negedge clk);
            check("poke_progress", 32'(got.size() >= 5), 32'd1);
            pulse_start(2'b11, ~code);
            pulse_start(2'b00, ~code);
        end
        for (int c = 0; c < 5000 && done_cnt == 0; c++) @(negedge clk);
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("busy_after_done", 32'(busy_o), 32'd0);
        check("done_once", 32'(done_cnt), 32'd1);
        check("no_err", 32'(err_cnt), 32'd0);
        check("frame_len", 32'(got.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size(); j++) begin
            check($sformatf("byte%0d", j), 32'(got[j]), 32'(exp_q[j]));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_byte"},  32'(byte_o),        32'd0);
        check({tag, "_valid"}, 32'(byte_valid_o),  32'd0);
        check({tag, "_cready"},32'(coeff_ready_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o),        32'd0);
        check({tag, "_done"},  32'(done_o),        32'd0);
        check({tag, "_err"},   32'(err_o),         32'd0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b0;
        start_i      = 1'b0;
        fft_select_i = 2'b00;
        src_n        = 0;
        src_idx      = 0;
        src_hold     = 1'b0;
        rdy_mode     = 0;
        done_cnt     = 0;
        err_cnt      = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #2;
        rst = 1'b1;

        // FFT8 ramp pattern, always-ready sink
        run_frame(2'b00, 0, 0, 1'b0, 1'b0);
        check("fft8_total", 32'(got.size()), 32'(35 + EXTRA));

        // FFT16 random data, ready 1-0-0
        run_frame(2'b01, 1, 1, 1'b0, 1'b0);
        check("fft16_total", 32'(got.size()), 32'(67 + EXTRA));

        // Invalid code
        got.delete();
        err_cnt = 0;
        @(posedge clk); #2;
        start_i      = 1'b1;
        fft_select_i = 2'b11;
        @(negedge clk);
        check("err_early", 32'(err_o), 32'd0);
        @(posedge clk); #2;
        start_i = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(err_o), 32'd1);
        check("err_busy", 32'(busy_o), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("err_valid_low", 32'(byte_valid_o), 32'd0);
            check("err_busy_low", 32'(busy_o), 32'd0);
        end
        check("err_once", 32'(err_cnt), 32'd1);
        check("err_no_bytes", 32'(got.size()), 32'd0);

        // FFT32 random backpressure with start requests while busy
        run_frame(2'b10, 2, 1, 1'b0, 1'b1);

        // FFT8 with coefficient starvation in the first LOAD
        run_frame(2'b00, 2, 1, 1'b1, 1'b0);

        // Reset in the middle of an FFT32 frame
        build(2'b10, 0);
        got.delete();
        done_cnt = 0;
        rdy_mode = 2;
        src_hold = 1'b0;
        pulse_start(2'b10, 2'b10);
        for (int c = 0; c < 500 && got.size() < 10; c++) @(negedge clk);
        check("abort_progress", 32'(got.size() >= 10), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        check("abort_no_done", 32'(done_cnt), 32'd0);
        for (int j = 0; j < got.size(); j++) begin
            check($sformatf("abort_prefix%0d", j), 32'(got[j]), 32'(exp_q[j]));
        end
        repeat (3) @(negedge clk);
        check_outputs_zero("hold_reset");
        @(posedge clk); #2;
        rst = 1'b1;
        run_frame(2'b00, 0, 1, 1'b0, 1'b0);

`ifdef FRAME_CHECKSUM_EN
        // Checksum of an all-zero FFT8 frame
        run_frame(2'b00, 0, 2, 1'b0, 1'b0);
        check("chk_total", 32'(got.size()), 32'd36);
        check("chk_byte", 32'(got[34]), 32'd0);
`endif

        // Random frames
        for (int t = 0; t < 4; t++) begin
            run_frame(2'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
